// File: rtl/l1_line_cache_pkg.sv
// Shared types for the L1 line cache: address/line typedefs, cache geometry
// and the controller state encoding.
package l1_line_cache_pkg;

  localparam int ADDR_BITS        = 12;
  localparam int LINE_BYTES       = 16;
  localparam int LINE_BITS        = LINE_BYTES * 8;
  localparam int CACHE_INDEX_BITS = 3;
  localparam int CACHE_NUM_SETS   = 1 << CACHE_INDEX_BITS;

  typedef logic [ADDR_BITS-1:0]                  lc3b_wb_adr;
  typedef logic [LINE_BITS-1:0]                  lc3b_line;
  typedef logic [LINE_BITS-1:0]                  lc3b_c_line;
  typedef logic [LINE_BYTES-1:0]                 lc3b_mem_sel;
  typedef logic [CACHE_INDEX_BITS-1:0]           lc3b_cache_index;
  typedef logic [ADDR_BITS-CACHE_INDEX_BITS-1:0] lc3b_cache_tag;

  typedef enum logic [1:0] {
    CS_IDLE,
    CS_CHECK,
    CS_WRITEBACK,
    CS_ALLOCATE
  } cache_state_e;

endpackage

// File: rtl/l1_line_cache_if.sv
// Core-side request/response bundle and memory-side line bus bundle.
interface l1_line_cache_if;
  import l1_line_cache_pkg::*;

  logic        mem_read;
  logic        mem_write;
  lc3b_wb_adr  mem_address;
  lc3b_c_line  mem_wdata;
  lc3b_mem_sel mem_sel;
  lc3b_line    mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_sel,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_sel,
    output mem_rdata, mem_resp
  );
endinterface

interface l1_pmem_if;
  import l1_line_cache_pkg::*;

  logic       pmem_read;
  logic       pmem_write;
  lc3b_wb_adr pmem_address;
  lc3b_line   pmem_wdata;
  lc3b_line   pmem_rdata;
  logic       pmem_resp;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/l1_line_cache_array.sv
// Line storage for the direct-mapped cache: byte-lane data, tags, valid and
// dirty bits. Synchronous write, asynchronous read of the indexed set.
module l1_line_cache_array
  import l1_line_cache_pkg::*;
#(
  parameter int NUM_SETS   = CACHE_NUM_SETS,
  parameter int INDEX_BITS = CACHE_INDEX_BITS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [INDEX_BITS-1:0]         index_i,
  input  logic                          data_we_i,
  input  lc3b_mem_sel                   byte_en_i,
  input  lc3b_line                      wdata_i,
  input  logic                          tag_we_i,
  input  logic [ADDR_BITS-INDEX_BITS-1:0] tag_i,
  input  logic                          set_valid_i,
  input  logic                          set_dirty_i,
  input  logic                          clear_dirty_i,
  output lc3b_line                      rdata_o,
  output logic [ADDR_BITS-INDEX_BITS-1:0] tag_o,
  output logic                          valid_o,
  output logic                          dirty_o
);

  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;

  logic [TAG_BITS-1:0] tag_q [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;

  // One storage column per byte lane so a partial write touches only its lanes.
  for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_lane
    logic [7:0] lane_q [NUM_SETS];

    always_ff @(posedge clk) begin
      if (data_we_i && byte_en_i[gi]) begin
        lane_q[index_i] <= wdata_i[gi*8 +: 8];
      end
    end

    assign rdata_o[gi*8 +: 8] = lane_q[index_i];
  end

  always_ff @(posedge clk) begin
    if (tag_we_i) begin
      tag_q[index_i] <= tag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (set_valid_i) begin
        valid_q[index_i] <= 1'b1;
      end
      if (set_dirty_i) begin
        dirty_q[index_i] <= 1'b1;
      end else if (clear_dirty_i) begin
        dirty_q[index_i] <= 1'b0;
      end
    end
  end

  assign tag_o   = tag_q[index_i];
  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];

endmodule

// File: rtl/l1_line_cache.sv
// Direct-mapped, write-back, write-allocate line cache between the core data
// port and line-granular physical memory.
module l1_line_cache
  import l1_line_cache_pkg::*;
#(
  parameter int NUM_SETS   = CACHE_NUM_SETS,
  parameter int INDEX_BITS = CACHE_INDEX_BITS
) (
  input logic             clk,
  input logic             reset,
  l1_line_cache_if.slave  core,
  l1_pmem_if.master       pmem
);

  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;

  cache_state_e state_q, state_d;
  lc3b_wb_adr   miss_addr_q, miss_addr_d;

  logic                  req;
  logic [INDEX_BITS-1:0] req_index, miss_index, arr_index;
  logic [TAG_BITS-1:0]   req_tag, miss_tag, arr_tag, arr_tag_wr;
  lc3b_line              arr_rdata, arr_wdata;
  lc3b_mem_sel           arr_byte_en;
  logic                  arr_valid, arr_dirty, hit;
  logic                  data_we, tag_we, set_valid, set_dirty, clear_dirty;
  logic                  resp, pread, pwrite;
  lc3b_wb_adr            paddr;

  assign req        = core.mem_read | core.mem_write;
  assign req_index  = core.mem_address[INDEX_BITS-1:0];
  assign req_tag    = core.mem_address[ADDR_BITS-1:INDEX_BITS];
  assign miss_index = miss_addr_q[INDEX_BITS-1:0];
  assign miss_tag   = miss_addr_q[ADDR_BITS-1:INDEX_BITS];

  // The miss address is latched so the memory transaction stays stable even
  // if the core withdraws its request mid-miss.
  assign arr_index = (state_q == CS_WRITEBACK || state_q == CS_ALLOCATE) ? miss_index : req_index;
  assign hit       = arr_valid && (arr_tag == req_tag);

  l1_line_cache_array #(
    .NUM_SETS   (NUM_SETS),
    .INDEX_BITS (INDEX_BITS)
  ) u_array (
    .clk           (clk),
    .reset         (reset),
    .index_i       (arr_index),
    .data_we_i     (data_we),
    .byte_en_i     (arr_byte_en),
    .wdata_i       (arr_wdata),
    .tag_we_i      (tag_we),
    .tag_i         (arr_tag_wr),
    .set_valid_i   (set_valid),
    .set_dirty_i   (set_dirty),
    .clear_dirty_i (clear_dirty),
    .rdata_o       (arr_rdata),
    .tag_o         (arr_tag),
    .valid_o       (arr_valid),
    .dirty_o       (arr_dirty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CS_IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    resp        = 1'b0;
    pread       = 1'b0;
    pwrite      = 1'b0;
    paddr       = miss_addr_q;
    data_we     = 1'b0;
    tag_we      = 1'b0;
    set_valid   = 1'b0;
    set_dirty   = 1'b0;
    clear_dirty = 1'b0;
    arr_byte_en = core.mem_sel;
    arr_wdata   = core.mem_wdata;
    arr_tag_wr  = miss_tag;

    case (state_q)
      CS_IDLE: begin
        if (req) begin
          state_d = CS_CHECK;
        end
      end

      CS_CHECK: begin
        if (!req) begin
          state_d = CS_IDLE;
        end else if (hit) begin
          resp    = 1'b1;
          state_d = CS_IDLE;
          if (core.mem_write) begin
            data_we   = 1'b1;
            set_dirty = |core.mem_sel;
          end
        end else begin
          miss_addr_d = core.mem_address;
          state_d     = (arr_valid && arr_dirty) ? CS_WRITEBACK : CS_ALLOCATE;
        end
      end

      CS_WRITEBACK: begin
        pwrite = 1'b1;
        paddr  = {arr_tag, miss_index};
        if (pmem.pmem_resp) begin
          clear_dirty = 1'b1;
          state_d     = CS_ALLOCATE;
        end
      end

      CS_ALLOCATE: begin
        pread = 1'b1;
        paddr = miss_addr_q;
        if (pmem.pmem_resp) begin
          data_we     = 1'b1;
          arr_byte_en = '1;
          arr_wdata   = pmem.pmem_rdata;
          tag_we      = 1'b1;
          set_valid   = 1'b1;
          clear_dirty = 1'b1;
          state_d     = CS_CHECK;
        end
      end

      default: state_d = CS_IDLE;
    endcase
  end

  assign core.mem_rdata    = arr_rdata;
  assign core.mem_resp     = resp;
  assign pmem.pmem_read    = pread;
  assign pmem.pmem_write   = pwrite;
  assign pmem.pmem_address = paddr;
  assign pmem.pmem_wdata   = arr_rdata;

endmodule

// File: tb/tb_l1_line_cache.sv
// Self-checking bench for l1_line_cache: directed scenarios then random traffic
// checked against a set-level cache model over a flat backing memory.
module tb_l1_line_cache;
  import l1_line_cache_pkg::*;

  localparam int NS = CACHE_NUM_SETS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l1_line_cache_if core ();
  l1_pmem_if       pmem ();

  l1_line_cache #(
    .NUM_SETS   (NS),
    .INDEX_BITS (CACHE_INDEX_BITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .core  (core),
    .pmem  (pmem)
  );

  logic     auto_resp = 1'b0;
  logic     man_resp  = 1'b0;
  lc3b_line auto_rdata = '0;
  lc3b_line man_rdata  = '0;
  assign pmem.pmem_resp  = auto_resp | man_resp;
  assign pmem.pmem_rdata = man_resp ? man_rdata : auto_rdata;

  int         errors = 0;
  int         checks = 0;
  bit         mem_auto = 1'b1;
  int         rd_count = 0;
  int         wr_count = 0;
  lc3b_wb_adr last_rd_addr = '0;
  lc3b_wb_adr last_wr_addr = '0;
  lc3b_line   last_wr_data = '0;
  bit         both_seen = 1'b0;
  int         txn = 0;

  lc3b_line store [int];
  lc3b_line ref_back [int];
  bit       m_valid [NS];
  bit       m_dirty [NS];
  int       m_tag   [NS];
  lc3b_line m_data  [NS];

  function automatic lc3b_line default_line(int a);
    logic [31:0] s;
    s = 32'(a) * 32'h9E3779B1 + 32'h01234567;
    return {s, ~s, s ^ 32'hA5A5A5A5, s + 32'd77};
  endfunction

  function automatic lc3b_line back_line(int a);
    return ref_back.exists(a) ? ref_back[a] : default_line(a);
  endfunction

  task automatic chk(input string tag, input lc3b_line obs, input lc3b_line exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: random latency, one-cycle pmem_resp pulse.
  initial begin
    int lat;
    lat = 0;
    forever begin
      @(negedge clk);
      if (pmem.pmem_read && pmem.pmem_write) both_seen = 1'b1;
      if (auto_resp) begin
        auto_resp = 1'b0;
      end else if (!reset && mem_auto && (pmem.pmem_read || pmem.pmem_write)) begin
        if (lat == 0) lat = $urandom_range(1, 4);
        lat--;
        if (lat == 0) begin
          if (pmem.pmem_write) begin
            store[int'(pmem.pmem_address)] = pmem.pmem_wdata;
            last_wr_addr = pmem.pmem_address;
            last_wr_data = pmem.pmem_wdata;
            wr_count++;
          end else begin
            auto_rdata = store.exists(int'(pmem.pmem_address)) ?
                         store[int'(pmem.pmem_address)] : default_line(int'(pmem.pmem_address));
            last_rd_addr = pmem.pmem_address;
            rd_count++;
          end
          auto_resp = 1'b1;
        end
      end else begin
        lat = 0;
      end
    end
  end

  task automatic do_req(input bit rd, input bit wr, input int a, input lc3b_line wd,
                        input lc3b_mem_sel sel, output lc3b_line rdata);
    int       idx, tg, vict, rd0, wr0, cycles;
    bit       hit, exp_wb, got;
    lc3b_line exp_wb_data, exp_rdata;
    idx  = a % NS;
    tg   = a / NS;
    hit  = m_valid[idx] && (m_tag[idx] == tg);
    exp_wb = !hit && m_valid[idx] && m_dirty[idx];
    vict = m_tag[idx] * NS + idx;
    exp_wb_data = m_data[idx];
    rd0 = rd_count;
    wr0 = wr_count;
    cycles = 0;
    got = 1'b0;
    rdata = '0;

    if (!hit) begin
      if (exp_wb) ref_back[vict] = m_data[idx];
      m_data[idx]  = back_line(a);
      m_tag[idx]   = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    exp_rdata = m_data[idx];
    if (wr) begin
      for (int b = 0; b < LINE_BYTES; b++)
        if (sel[b]) m_data[idx][b*8 +: 8] = wd[b*8 +: 8];
      if (sel != '0) m_dirty[idx] = 1'b1;
    end

    core.mem_read    = rd;
    core.mem_write   = wr;
    core.mem_address = lc3b_wb_adr'(a);
    core.mem_wdata   = wd;
    core.mem_sel     = sel;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      cycles++;
      if (core.mem_resp) begin
        got = 1'b1;
        rdata = core.mem_rdata;
        break;
      end
    end
    chk("resp_seen", lc3b_line'(got), lc3b_line'(1));
    if (got) begin
      @(negedge clk);
      chk("resp_single_pulse", lc3b_line'(core.mem_resp), lc3b_line'(0));
    end
    core.mem_read  = 1'b0;
    core.mem_write = 1'b0;

    chk("rdata", rdata, exp_rdata);
    chk("writeback_count", lc3b_line'(wr_count - wr0), lc3b_line'(exp_wb));
    if (exp_wb) begin
      chk("writeback_addr", lc3b_line'(last_wr_addr), lc3b_line'(vict));
      chk("writeback_data", last_wr_data, exp_wb_data);
    end
    chk("fill_count", lc3b_line'(rd_count - rd0), lc3b_line'(!hit));
    if (!hit) chk("fill_addr", lc3b_line'(last_rd_addr), lc3b_line'(a));
    if (hit) chk("hit_latency", lc3b_line'(cycles), lc3b_line'(1));
    else     chk("miss_latency_gt1", lc3b_line'(cycles > 1), lc3b_line'(1));

    txn++;
    $display("txn %0d rd=%0d wr=%0d addr=%03h sel=%04h hit=%0d wb=%0d cycles=%0d",
             txn, rd, wr, a, sel, hit, exp_wb, cycles);
    @(negedge clk);
  endtask

  initial begin
    lc3b_line r;
    lc3b_line a5;
    lc3b_line merged;
    lc3b_line wd;
    bit       seen;
    int       kind, ssel;
    lc3b_mem_sel sel;

    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 0;
      m_data[i]  = '0;
    end
    a5 = {16{8'hA5}};
    store[5]    = a5;
    ref_back[5] = a5;

    core.mem_read = 1'b0;
    core.mem_write = 1'b0;
    core.mem_address = '0;
    core.mem_wdata = '0;
    core.mem_sel = '0;
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mem_resp", lc3b_line'(core.mem_resp), lc3b_line'(0));
    chk("reset_pmem_read", lc3b_line'(pmem.pmem_read), lc3b_line'(0));
    chk("reset_pmem_write", lc3b_line'(pmem.pmem_write), lc3b_line'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_req(1, 0, 12'h005, '0, '0, r);
    chk("first_read_a5", r, a5);
    do_req(1, 0, 12'h005, '0, '0, r);
    do_req(0, 1, 12'h005, {112'h0, 16'hBEEF}, 16'h0003, r);
    do_req(1, 0, 12'h005, '0, '0, r);
    merged = {a5[127:16], 16'hBEEF};
    chk("merged_line", r, merged);
    do_req(1, 0, 12'h00D, '0, '0, r);
    chk("dirty_victim_data", last_wr_data, merged);
    chk("dirty_victim_addr", lc3b_line'(last_wr_addr), lc3b_line'(12'h005));
    do_req(1, 0, 12'h015, '0, '0, r);
    wd = {4{32'hC0FFEE11}};
    do_req(1, 1, 12'h003, wd, 16'hFFFF, r);
    do_req(1, 0, 12'h003, '0, '0, r);
    chk("both_high_written", r, wd);
    do_req(1, 0, 12'h00B, '0, '0, r);
    chk("both_high_dirty_wb", last_wr_data, wd);

    // Reset while a fill is outstanding; the late pmem_resp must be ignored.
    mem_auto = 1'b0;
    core.mem_read = 1'b1;
    core.mem_address = 12'h025;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pmem.pmem_read) begin
        seen = 1'b1;
        break;
      end
    end
    chk("alloc_reached", lc3b_line'(seen), lc3b_line'(1));
    chk("alloc_addr", lc3b_line'(pmem.pmem_address), lc3b_line'(12'h025));
    reset = 1'b1;
    core.mem_read = 1'b0;
    @(negedge clk);
    chk("midmiss_reset_resp", lc3b_line'(core.mem_resp), lc3b_line'(0));
    chk("midmiss_reset_pread", lc3b_line'(pmem.pmem_read), lc3b_line'(0));
    chk("midmiss_reset_pwrite", lc3b_line'(pmem.pmem_write), lc3b_line'(0));
    reset = 1'b0;
    man_resp = 1'b1;
    man_rdata = {8{16'hDEAD}};
    @(negedge clk);
    man_resp = 1'b0;
    @(negedge clk);
    chk("late_resp_ignored_pread", lc3b_line'(pmem.pmem_read), lc3b_line'(0));
    chk("late_resp_ignored_resp", lc3b_line'(core.mem_resp), lc3b_line'(0));
    mem_auto = 1'b1;
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    do_req(1, 0, 12'h025, '0, '0, r);
    do_req(1, 0, 12'h003, '0, '0, r);

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 2);
      ssel = $urandom_range(0, 5);
      sel  = (ssel == 0) ? 16'h0000 : (ssel == 1) ? 16'hFFFF : lc3b_mem_sel'($urandom);
      wd   = {$urandom, $urandom, $urandom, $urandom};
      do_req(kind != 1, kind != 0, $urandom_range(0, 31), wd, sel, r);
    end

    chk("pmem_rw_exclusive", lc3b_line'(both_seen), lc3b_line'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
